// File: rtl/uart_cmd_decoder.sv
// UART command parser: "CH<d>[<d>]<CR|LF>" selects an XADC channel, "R<CR|LF>" requests a readout.
// Optional terminal echo of received bytes is built when UART_CMD_ECHO_EN is defined.
module uart_cmd_decoder #(
  parameter int unsigned NUM_CH         = 13,
  parameter int unsigned DEF_CH         = 7,
  parameter int unsigned TIMEOUT_CYCLES = 10_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [3:0] ch_sel,
  output logic [7:0] daddr,
  output logic       cmd_valid,
  output logic       read_req,
  output logic       err,
  output logic       busy,
  output logic [7:0] tx_data,
  output logic       tx_wr
);

  localparam int unsigned CW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [6:0]  NUM_CH_W = 7'(NUM_CH);
  localparam logic [3:0]  DEF_CH_W = 4'(DEF_CH);

  typedef enum logic [2:0] {
    IDLE, GOT_C, GOT_H, DIG1, DIG2, GOT_R, DISCARD
  } state_t;

  state_t        state, state_nx;
  logic [6:0]    acc, acc_nx;
  logic          load_ch;
  logic          cmd_nx, rd_nx, err_nx;
  logic [CW-1:0] tmo_cnt;
  logic          tmo_hit;
  logic          is_term, is_digit, is_c, is_h, is_r;
  logic [3:0]    digit;

  function automatic logic [7:0] ch_to_daddr(input logic [3:0] ch);
    if (ch == 4'd0) return 8'h03;
    return 8'h10 + {4'h0, ch} - 8'h01;
  endfunction

  assign is_term  = (rx_data == 8'h0D) || (rx_data == 8'h0A);
  assign is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
  assign is_c     = (rx_data == 8'h43) || (rx_data == 8'h63);
  assign is_h     = (rx_data == 8'h48) || (rx_data == 8'h68);
  assign is_r     = (rx_data == 8'h52) || (rx_data == 8'h72);
  assign digit    = rx_data[3:0];

  // A received byte always takes precedence over an expiring timeout.
  assign tmo_hit = (state != IDLE) && !rx_valid && (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign busy    = (state != IDLE);

  always_comb begin
    state_nx = state;
    acc_nx   = acc;
    load_ch  = 1'b0;
    cmd_nx   = 1'b0;
    rd_nx    = 1'b0;
    err_nx   = 1'b0;
    if (rx_valid) begin
      // Errors decided on a terminator end the line here instead of discarding.
      unique case (state)
        IDLE: begin
          if (is_term) begin
            state_nx = IDLE;
          end else if (is_c) begin
            state_nx = GOT_C;
          end else if (is_r) begin
            state_nx = GOT_R;
          end else begin
            err_nx   = 1'b1;
            state_nx = DISCARD;
          end
        end
        GOT_C: begin
          if (is_h) begin
            state_nx = GOT_H;
          end else begin
            err_nx   = 1'b1;
            state_nx = is_term ? IDLE : DISCARD;
          end
        end
        GOT_H: begin
          if (is_digit) begin
            acc_nx   = {3'b000, digit};
            state_nx = DIG1;
          end else begin
            err_nx   = 1'b1;
            state_nx = is_term ? IDLE : DISCARD;
          end
        end
        DIG1, DIG2: begin
          if (is_term) begin
            state_nx = IDLE;
            if (acc < NUM_CH_W) begin
              load_ch = 1'b1;
              cmd_nx  = 1'b1;
            end else begin
              err_nx = 1'b1;
            end
          end else if (is_digit && state == DIG1) begin
            acc_nx   = acc * 7'd10 + {3'b000, digit};
            state_nx = DIG2;
          end else begin
            err_nx   = 1'b1;
            state_nx = DISCARD;
          end
        end
        GOT_R: begin
          if (is_term) begin
            rd_nx    = 1'b1;
            state_nx = IDLE;
          end else begin
            err_nx   = 1'b1;
            state_nx = DISCARD;
          end
        end
        DISCARD: begin
          if (is_term) state_nx = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end else if (tmo_hit) begin
      err_nx   = (state != DISCARD);
      state_nx = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      ch_sel    <= DEF_CH_W;
      daddr     <= ch_to_daddr(DEF_CH_W);
      cmd_valid <= 1'b0;
      read_req  <= 1'b0;
      err       <= 1'b0;
      tmo_cnt   <= '0;
    end else begin
      state     <= state_nx;
      acc       <= acc_nx;
      cmd_valid <= cmd_nx;
      read_req  <= rd_nx;
      err       <= err_nx;
      if (load_ch) begin
        ch_sel <= acc[3:0];
        daddr  <= ch_to_daddr(acc[3:0]);
      end
      if (rx_valid || state == IDLE || state_nx == IDLE) tmo_cnt <= '0;
      else                                              tmo_cnt <= tmo_cnt + CW'(1);
    end
  end

`ifdef UART_CMD_ECHO_EN
  logic       lf_pend, hold_v;
  logic [7:0] hold;
  logic [7:0] src;
  logic       src_v, src_hold, rx_to_hold;

  // Output order: pending LF, then the held byte, then the live byte; a byte
  // arriving while an older one is still queued waits one cycle in hold.
  always_comb begin
    src      = '0;
    src_v    = 1'b1;
    src_hold = 1'b0;
    if (lf_pend) begin
      src = 8'h0A;
    end else if (hold_v) begin
      src      = hold;
      src_hold = 1'b1;
    end else if (rx_valid) begin
      src = rx_data;
    end else begin
      src_v = 1'b0;
    end
  end

  assign rx_to_hold = rx_valid && (lf_pend || hold_v);

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_data <= '0;
      tx_wr   <= 1'b0;
      lf_pend <= 1'b0;
      hold_v  <= 1'b0;
      hold    <= '0;
    end else begin
      tx_wr <= src_v;
      if (src_v) tx_data <= src;
      lf_pend <= src_v && (src == 8'h0D);
      if (rx_to_hold) begin
        hold   <= rx_data;
        hold_v <= 1'b1;
      end else if (src_hold) begin
        hold_v <= 1'b0;
      end
    end
  end
`else
  assign tx_data = '0;
  assign tx_wr   = 1'b0;
`endif

endmodule
